// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC datapath: default operand widths,
// the number of source beats per operand matrix, and the collector state encoding.
package systolic_pkg;

  localparam int IN_WIDTH_DEF  = 64;
  localparam int OUT_WIDTH_DEF = 512;
  localparam int BEATS         = OUT_WIDTH_DEF / IN_WIDTH_DEF;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    BUSY
  } state_t;

endpackage

// File: rtl/operand_packer.sv
// Word-addressed operand register. It holds BEATS words of IN_WIDTH bits each.
// A write replaces only the selected word and leaves the other words unchanged.
// Word k occupies bits [k*IN_WIDTH +: IN_WIDTH], so word 0 is the least-significant word.
module operand_packer #(
  parameter int IN_WIDTH = systolic_pkg::IN_WIDTH_DEF,
  parameter int BEATS    = systolic_pkg::BEATS,
  localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int OUT_WIDTH = IN_WIDTH * BEATS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [IN_WIDTH-1:0]  wr_data,
  output logic [OUT_WIDTH-1:0] data
);

  // Write the addressed word in place; an asynchronous clear zeroes the whole matrix
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < BEATS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          data[k*IN_WIDTH +: IN_WIDTH] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/operand_collector.sv
// operand_collector: input stage of the systolic MAC datapath.
//
// Operation:
//   - Collects IN_WIDTH-bit beats into operand matrix A, then into operand matrix B.
//   - Pulses rx_done when the last beat has been accepted.
//   - Pulses start_matrix_mult to the array one cycle after rx_done.
//   - Holds dest_ready low until the array reports done_matrix_mult.
//
// Optional feature (macro WEIGHT_REUSE_EN):
//   - Adds the input reuse_b, which is sampled on the last A beat.
//   - When reuse_b is 1, the B load is skipped and the previous matrix_b is kept.
module operand_collector
  import systolic_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_valid,
  input  logic [IN_WIDTH-1:0]  src_data,
  output logic                 dest_ready,
  output logic [OUT_WIDTH-1:0] matrix_a,
  output logic [OUT_WIDTH-1:0] matrix_b,
  output logic                 start_matrix_mult,
  input  logic                 done_matrix_mult,
`ifdef WEIGHT_REUSE_EN
  input  logic                 reuse_b,
`endif
  output logic                 rx_done
);

  localparam int MATRIX_BEATS = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W        = (MATRIX_BEATS > 1) ? $clog2(MATRIX_BEATS) : 1;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic              xfer;
  logic              last_beat;
  logic              skip_b;
  logic [CNT_W-1:0]  next_cnt;

  assign xfer      = src_valid && dest_ready;
  assign last_beat = (beat_cnt == CNT_W'(MATRIX_BEATS - 1));
  assign next_cnt  = last_beat ? '0 : beat_cnt + 1'b1;

`ifdef WEIGHT_REUSE_EN
  assign skip_b = reuse_b;
`else
  assign skip_b = 1'b0;
`endif

  // Control FSM. All of its outputs are registered.
  // - dest_ready is high only while loading.
  // - A done that arrives during the start-pulse cycle is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= LOAD_A;
      beat_cnt          <= '0;
      dest_ready        <= 1'b0;
      start_matrix_mult <= 1'b0;
      rx_done           <= 1'b0;
    end else begin
      start_matrix_mult <= 1'b0;
      rx_done           <= 1'b0;
      case (state)
        LOAD_A: begin
          dest_ready <= 1'b1;
          if (xfer) begin
            beat_cnt <= next_cnt;
            if (last_beat) begin
              if (skip_b) begin
                state      <= START;
                dest_ready <= 1'b0;
                rx_done    <= 1'b1;
              end else begin
                state <= LOAD_B;
              end
            end
          end
        end
        LOAD_B: begin
          dest_ready <= 1'b1;
          if (xfer) begin
            beat_cnt <= next_cnt;
            if (last_beat) begin
              state      <= START;
              dest_ready <= 1'b0;
              rx_done    <= 1'b1;
            end
          end
        end
        START: begin
          dest_ready        <= 1'b0;
          start_matrix_mult <= 1'b1;
          state             <= BUSY;
        end
        BUSY: begin
          dest_ready <= 1'b0;
          if (done_matrix_mult && !start_matrix_mult) begin
            state      <= LOAD_A;
            dest_ready <= 1'b1;
          end
        end
        default: begin
          state      <= LOAD_A;
          dest_ready <= 1'b0;
        end
      endcase
    end
  end

  logic wr_a;
  logic wr_b;

  assign wr_a = xfer && (state == LOAD_A);
  assign wr_b = xfer && (state == LOAD_B);

  operand_packer #(
    .IN_WIDTH (IN_WIDTH),
    .BEATS    (MATRIX_BEATS)
  ) u_pack_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_a),
    .wr_idx  (beat_cnt),
    .wr_data (src_data),
    .data    (matrix_a)
  );

  operand_packer #(
    .IN_WIDTH (IN_WIDTH),
    .BEATS    (MATRIX_BEATS)
  ) u_pack_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_b),
    .wr_idx  (beat_cnt),
    .wr_data (src_data),
    .data    (matrix_b)
  );

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking testbench for operand_collector.
// A table of per-cycle vectors covers the basic load/start/busy flow.
// Hand-written sequences cover handshake gaps, done handling, mid-load reset,
// and, when WEIGHT_REUSE_EN is defined, weight reuse.
module tb_operand_collector;

  localparam int IW = 64;
  localparam int OW = 512;
  localparam int NB = OW / IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          src_valid;
  logic [IW-1:0] src_data;
  logic          dest_ready;
  logic [OW-1:0] matrix_a;
  logic [OW-1:0] matrix_b;
  logic          start_matrix_mult;
  logic          done_matrix_mult;
  logic          reuse_b_drv;
  logic          rx_done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic          valid;
    logic [IW-1:0] data;
    logic          done;
    logic          exp_ready;
    logic          exp_rx;
    logic          exp_start;
  } vec_t;

  vec_t vecs[$];

  operand_collector #(
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .dest_ready        (dest_ready),
    .matrix_a          (matrix_a),
    .matrix_b          (matrix_b),
    .start_matrix_mult (start_matrix_mult),
    .done_matrix_mult  (done_matrix_mult),
`ifdef WEIGHT_REUSE_EN
    .reuse_b           (reuse_b_drv),
`endif
    .rx_done           (rx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [OW-1:0] buildMatrix(input logic [IW-1:0] base);
    logic [OW-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) m[k*IW +: IW] = base + IW'(k);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [IW-1:0] data, input logic done);
    src_valid        = valid;
    src_data         = data;
    done_matrix_mult = done;
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string name, input logic er, input logic ex, input logic es);
    checkBit({name, "_ready"}, dest_ready, er);
    checkBit({name, "_rx"}, rx_done, ex);
    checkBit({name, "_start"}, start_matrix_mult, es);
  endtask

  // Offer n beats base, base+1, ... and advance only on an actual transfer.
  task automatic sendBeats(input logic [IW-1:0] base, input int n, input logic reuse_last, output int starts);
    int   i      = 0;
    int   budget = 0;
    logic xfer;
    starts = 0;
    done_matrix_mult = 1'b0;
    while (i < n && budget < 200) begin
      src_valid   = 1'b1;
      src_data    = base + IW'(i);
      reuse_b_drv = reuse_last && (i == NB - 1);
      xfer        = dest_ready;
      @(posedge clk);
      #1;
      if (start_matrix_mult) starts++;
      if (xfer) i++;
      budget++;
    end
    src_valid   = 1'b0;
    reuse_b_drv = 1'b0;
    checkOutput("send_complete", OW'(i), OW'(n));
  endtask

  initial begin
    int starts;
    reset            = 1'b0;
    src_valid        = 1'b0;
    src_data         = '0;
    done_matrix_mult = 1'b0;
    reuse_b_drv      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_a", matrix_a, '0);
    checkOutput("reset_b", matrix_b, '0);
    reset = 1'b1;

    // Test 1 and test 3 flow as a vector table
    vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 2*NB; k++)
      vecs.push_back('{1'b1, IW'(k), 1'b0, (k != 2*NB-1), (k == 2*NB-1), 1'b0});
    vecs.push_back('{1'b1, 64'h10, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 20; k++)
      vecs.push_back('{1'b1, 64'hDEAD_0000 + IW'(k), 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0});

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].valid, vecs[v].data, vecs[v].done);
      checkFlags($sformatf("vec%0d", v), vecs[v].exp_ready, vecs[v].exp_rx, vecs[v].exp_start);
      if (v == 2*NB + 21) begin
        checkOutput("t1_a_word0", {448'b0, matrix_a[63:0]}, OW'(64'h0));
        checkOutput("t1_a_word7", {448'b0, matrix_a[511:448]}, OW'(64'h7));
        checkOutput("t1_b_word0", {448'b0, matrix_b[63:0]}, OW'(64'h8));
        checkOutput("t1_b_word7", {448'b0, matrix_b[511:448]}, OW'(64'hF));
        checkOutput("t3_busy_a", matrix_a, buildMatrix(64'h0));
        checkOutput("t3_busy_b", matrix_b, buildMatrix(64'h8));
      end
    end

    // Test 2 and test 4: toggling src_valid; done high during A load and around start
    for (int k = 0; k < 2*NB; k++) begin
      applyStimulus(1'b1, 64'h100 + IW'(k), k < NB);
      checkFlags($sformatf("t2_beat%0d", k), k != 2*NB-1, k == 2*NB-1, 1'b0);
      if (k != 2*NB-1) begin
        applyStimulus(1'b0, 64'hBAD0 + IW'(k), k < NB);
        checkFlags($sformatf("t2_gap%0d", k), 1'b1, 1'b0, 1'b0);
      end
    end
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkFlags("t4_start_cycle", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkFlags("t4_done_in_start_ignored", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkFlags("t4_done_in_busy", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkFlags("t4_done_held", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("t2_a", matrix_a, buildMatrix(64'h100));
    checkOutput("t2_b", matrix_b, buildMatrix(64'h108));

    // Test 5: reset after five A beats, then a full clean load
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 64'hC0 + IW'(k), 1'b0);
    src_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkFlags("t5_in_reset", 1'b0, 1'b0, 1'b0);
    checkOutput("t5_reset_a", matrix_a, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkBit("t5_no_start_in_reset", start_matrix_mult, 1'b0);
    end
    reset = 1'b1;
    sendBeats(64'hA0, 2*NB, 1'b0, starts);
    checkOutput("t5_no_early_start", OW'(starts), OW'(0));
    checkBit("t5_rx", rx_done, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkBit("t5_start", start_matrix_mult, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkBit("t5_single_start", start_matrix_mult, 1'b0);
    checkOutput("t5_a_word0", {448'b0, matrix_a[63:0]}, OW'(64'hA0));
    checkOutput("t5_a", matrix_a, buildMatrix(64'hA0));
    checkOutput("t5_b", matrix_b, buildMatrix(64'hA8));
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkBit("t5_back_to_load", dest_ready, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0);

`ifdef WEIGHT_REUSE_EN
    // Test 6: the second job reuses the B from the first job
    sendBeats(64'h200, 2*NB, 1'b0, starts);
    checkBit("t6_job1_rx", rx_done, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkBit("t6_job1_start", start_matrix_mult, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkBit("t6_job1_done", dest_ready, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0);
    sendBeats(64'h300, NB, 1'b1, starts);
    checkFlags("t6_reuse_rx", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkBit("t6_reuse_start", start_matrix_mult, 1'b1);
    checkOutput("t6_a", matrix_a, buildMatrix(64'h300));
    checkOutput("t6_b_kept", matrix_b, buildMatrix(64'h208));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
